// File: rtl/spram_pkg.sv
// Shared types and default widths for the single-port RAM initiator
// and the single_port_ram instances it drives.
package spram_pkg;

  localparam int SPRAM_DW = 8;
  localparam int SPRAM_AW = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    RSP     = 3'd4,
    INIT    = 3'd5
  } state_e;

endpackage

// File: rtl/spram_initiator.sv
// Client-side sequencer for a single-port RAM with one-cycle read latency.
// Optional SPRAM_INIT_CLEAR_EN: zero-fill sweep of the RAM after reset.
module spram_initiator
  import spram_pkg::*;
#(
  parameter int DATA_WIDTH = SPRAM_DW,
  parameter int ADDR_WIDTH = SPRAM_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  wr_ack,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  state_e                  state_q, state_d;
  logic                    mem_en_q, mem_en_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
  logic                    wr_ack_q, wr_ack_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    accept;

`ifdef SPRAM_INIT_CLEAR_EN
  localparam state_e RST_STATE = INIT;
  localparam logic   RST_EN    = 1'b1;
`else
  localparam state_e RST_STATE = IDLE;
  localparam logic   RST_EN    = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign wr_ack    = wr_ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // Next state and next value of every registered output.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mem_addr_d = req_addr;
          mem_din_d  = req_wdata;
          state_d    = req_we ? WRITE : READ;
        end
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        rsp_rdata_d = mem_dout;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      INIT: begin
`ifdef SPRAM_INIT_CLEAR_EN
        mem_din_d = '0;
        if (mem_addr_q == '1) begin
          state_d = IDLE;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    // Strobes follow the state they belong to, so register them from state_d.
    mem_en_d = (state_d == WRITE) || (state_d == INIT);
    wr_ack_d = (state_d == WRITE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      mem_en_q    <= RST_EN;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      wr_ack_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      wr_ack_q    <= wr_ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: doc/spram_initiator.md
Name: spram_initiator

Overview:
- Request-side controller that drives the team's single-port RAM (write-when-enabled, registered read otherwise) on behalf of a client.
- Client side: valid/ready request channel and valid/ready read-response channel. Memory side: en/addr/data_in out, registered read data in.
- Sequences every RAM access with correct one-cycle read latency.
- Sits between any bus/agent logic and a single_port_ram instance at the same level.

Parameters:
DATA_WIDTH, 8, width of data words (must match RAM)
ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  client request present
req_ready  out  1  controller can accept request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
wr_ack  out  1  one-cycle pulse: write issued to RAM
rsp_valid  out  1  read data available
rsp_ready  in  1  client accepts read data
rsp_rdata  out  DATA_WIDTH  read data
mem_en  out  1  to RAM en (1 = write, 0 = read)
mem_addr  out  ADDR_WIDTH  to RAM addr
mem_din  out  DATA_WIDTH  to RAM data_in
mem_dout  in  DATA_WIDTH  from RAM registered data

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE; mem_en=0; mem_addr=0; mem_din=0; wr_ack=0; rsp_valid=0; rsp_rdata=0.
  - Any in-flight access is dropped.
- All outputs are registered except req_ready, which is combinational: req_ready = (state==IDLE).
- Accept: in IDLE, req_valid && req_ready at an edge latches we/addr/wdata into mem_addr/mem_din.
- States:
  - IDLE: mem_en=0. On accept: go to WRITE if req_we, else READ.
  - WRITE (1 cycle): mem_en=1, wr_ack=1. RAM writes at the closing edge. Next state: IDLE. mem_en and wr_ack return to 0.
  - READ (1 cycle): mem_en=0, mem_addr held. RAM captures mem[addr] at the closing edge. Next state: CAPTURE.
  - CAPTURE (1 cycle): at the closing edge, rsp_rdata<=mem_dout and rsp_valid<=1. Next state: RSP.
  - RSP: rsp_valid and rsp_rdata held stable until rsp_ready. On the rsp_valid && rsp_ready edge, rsp_valid<=0 and next state is IDLE.
- Timing, with accept in cycle 0:
  - Write: mem_en high in cycle 1; req_ready high again in cycle 2. Write throughput is 1 per 2 cycles.
  - Read: rsp_valid first high in cycle 3. If rsp_ready is already high, req_ready is high in cycle 4.
- mem_en is 0 in every state except WRITE (and INIT, if compiled in). Idle cycles therefore perform harmless RAM reads.
- Only one transaction is outstanding at a time; no request pipelining.
- Client boundary conditions:
  - req_valid while not ready: request held by the client, not lost.
  - Request fields may change freely while req_ready=0.
- Address range: addr wraps naturally at 2**ADDR_WIDTH; there is no range check.
- Read-after-write to the same address returns the new data, because the write completes before the next accept.
- rst asserted in any state forces the reset values on the next edge. A pending response is discarded, and rsp_valid drops with no handshake.

Optional Feature:
SPRAM_INIT_CLEAR_EN
- Defined:
  - After reset, the FSM enters INIT instead of IDLE.
  - An ADDR_WIDTH counter sweeps 0..2**ADDR_WIDTH-1 with mem_en=1 and mem_din=0, one address per cycle.
  - Then go to IDLE. INIT takes 2**ADDR_WIDTH cycles (16 at default).
  - req_ready=0 and wr_ack=0 throughout INIT.
  - rst during INIT restarts the sweep at address 0.
- Undefined: no INIT state or counter; IDLE directly after reset. RAM contents are undefined until written.

Decomposition:
- Shared package spram_pkg:
  - state encoding constants: IDLE, WRITE, READ, CAPTURE, RSP, INIT.
  - default DATA_WIDTH/ADDR_WIDTH constants, shared with single_port_ram instantiations.
- No sub-module. The FSM plus its output registers form a single block. The RAM is instantiated alongside by the parent, not inside.

Test Plan:
- Write then read: write addr 0x3, data 0xA5 -> wr_ack pulse in cycle 1 with mem_en=1, mem_addr=0x3, mem_din=0xA5. Then read 0x3 -> rsp_valid in cycle 3, rsp_rdata=0xA5.
- Response backpressure: read 0x3 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata=0xA5 stable, req_ready=0. Raise rsp_ready -> rsp_valid clears next edge, req_ready=1.
- Address wrap: write 0x11 to 0xF and 0x22 to 0x0, read both -> 0x11 and 0x22; no aliasing.
- Back-to-back writes: req_valid held high with 4 writes to addrs 0..3 (data 0x10..0x13) -> one accept every 2 cycles. Readback returns 0x10..0x13.
- Reset mid-read: assert rst during CAPTURE -> next cycle rsp_valid=0, mem_en=0, req_ready=1 (macro off). No response is ever emitted.
- SPRAM_INIT_CLEAR_EN: write 0xFF to 0x7, then reset -> 16 cycles of mem_en=1 with mem_addr 0..15 and req_ready=0. Read 0x7 -> 0x00.
